fit_out_merge: RTL and testbench
================================

FIT_OUT_MERGE -- requirements
Module: fit_out_merge

Interface
REQ-001 SHALL have parameter NCH, default 4, giving the number of fitter output channels.
REQ-002 SHALL have parameter W, default 32, giving the data word width.
REQ-003 SHALL have parameter MAX_BURST, default 16, giving the maximum words taken from one channel per grant.
REQ-004 clock  in  1  single clock for all logic.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 ch_enable  in  NCH  per-channel participation mask, sampled in IDLE only.
REQ-007 ch_empty  in  NCH  per-channel FWFT FIFO empty flag.
REQ-008 ch_data  in  NCH*W  per-channel FIFO head word; channel i occupies bits [i*W +: W].
REQ-009 ch_ee  in  NCH  per-channel flag marking the head word as that channel's end-event marker.
REQ-010 ch_re  out  NCH  per-channel FIFO read strobe, combinational, at most one bit high.
REQ-011 out_afull  in  1  downstream almost-full flag; no write is issued in any cycle where it is high.
REQ-012 out_data  out  W  merged output word, registered.
REQ-013 out_we  out  1  output write strobe, registered.
REQ-014 out_ee  out  1  qualifies out_data as the merged end-event word, registered.
REQ-015 busy  out  1  high in every state except IDLE.

Function
REQ-016 SHALL implement the states IDLE, SELECT, XFER and SEND_EE.
REQ-017 IDLE: SHALL latch ch_enable into active_mask and clear ee_seen[NCH]; SHALL go to SELECT when active_mask is non-zero, otherwise stay in IDLE.
REQ-018 SELECT: SHALL grant the first channel at or after rr_ptr, wrapping modulo NCH, that is active, has ee_seen=0 and is non-empty, and SHALL go to XFER with burst_cnt=0.
REQ-019 SELECT: SHALL stay in SELECT when no channel qualifies; SHALL go to SEND_EE when every active channel has ee_seen=1.
REQ-020 XFER: when ~ch_empty[g] and ~out_afull, SHALL assert ch_re[g].
REQ-021 XFER: a non-marker word read under REQ-020 SHALL appear on out_data with out_we=1 and out_ee=0 exactly one cycle after the read.
REQ-022 XFER: a marker word (ch_ee[g]=1) SHALL be read and discarded without a write, SHALL set ee_seen[g], set rr_ptr=g+1 mod NCH and go to SELECT.
REQ-023 XFER: when burst_cnt reaches MAX_BURST, or ch_empty[g]=1, SHALL set rr_ptr=g+1 mod NCH and go to SELECT without clearing ee_seen.
REQ-024 XFER: when out_afull=1, SHALL hold the grant with no read and no write; burst_cnt SHALL count reads only.
REQ-025 SEND_EE: when ~out_afull, SHALL write one word with out_ee=1 and out_data={zeros, evt_cnt[7:0]}, increment evt_cnt (8-bit, wraps 255->0) and return to IDLE; SHALL wait in SEND_EE while out_afull=1.
REQ-026 Event integrity: no word from event N+1 SHALL be forwarded before the end-event word of event N.
REQ-027 Changes on ch_enable outside IDLE SHALL have no effect until the next IDLE.
REQ-028 Throughput: SHALL sustain one word per cycle within a burst; switching channels SHALL cost exactly one SELECT cycle.

Reset
REQ-029 Reset SHALL force IDLE and clear rr_ptr, burst_cnt, evt_cnt, ee_seen and active_mask to 0.
REQ-030 Reset SHALL drive out_we, out_ee, out_data and ch_re to 0 in the cycle after reset is sampled high.
REQ-031 Reset asserted mid-XFER SHALL abandon the event with no further output; the words already written SHALL NOT be recalled.

Structure
REQ-032 A shared package SHALL hold the state encoding constants and the defaults of NCH, W and MAX_BURST.
REQ-033 The round-robin first-qualifying-channel search SHALL be a sub-module named rr_pick (inputs req and ptr; outputs grant index and valid), combinational.
REQ-034 SHALL be a single clock domain with no internal FIFO.

Verification
REQ-035 Test 1, NCH=4, all enabled, each channel holds 3 words plus a marker -> 12 data writes, then one ee word with out_data=0; channel order 0,1,2,3.
REQ-036 Test 2, channel 0 holds 40 words plus a marker, channels 1-3 hold a marker only -> channel 0 bursts of 16,16,8 interleaved with the channel 1-3 markers; one ee word last.
REQ-037 Test 3, out_afull toggled every 3 cycles during a transfer -> no write and no ch_re while out_afull is high; no word lost or duplicated.
REQ-038 Test 4, ch_enable=4'b0101 -> channels 1 and 3 never read; ee word after the markers of channels 0 and 2 only.
REQ-039 Test 5, 257 events -> ee payloads run 0..255, then 0.
REQ-040 Test 6, reset asserted mid-XFER with 5 words pending -> outputs 0 on the next cycle; after reset, the next ee payload is 0.

Source files
------------

// File: rtl/fit_out_merge_pkg.sv
// fit_out_merge_pkg
// Shared definitions for the fitter output merger: parameter defaults and
// the FSM state encoding, which is also exported on the debug state output.
package fit_out_merge_pkg;

  localparam int NCH_DEF       = 4;
  localparam int W_DEF         = 32;
  localparam int MAX_BURST_DEF = 16;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SELECT  = 2'd1,
    S_XFER    = 2'd2,
    S_SEND_EE = 2'd3
  } state_t;

endpackage

// File: rtl/fit_out_merge_if.sv
// fit_out_merge_if
// Bundles the channel-side FIFO signals and the merged output stream.
//   ch_enable[NCH]   participation mask (used when the merger is idle)
//   ch_empty[NCH]    FWFT FIFO empty flags
//   ch_data[NCH*W]   FIFO head words, channel i at [i*W +: W]
//   ch_ee[NCH]       head word is that channel's end-event marker
//   ch_re[NCH]       FIFO read strobes (at most one high)
//   out_afull        downstream almost-full
//   out_data/we/ee   merged output word, write strobe, end-event qualifier
//   busy, dbg_state  status and FSM state for observation
//
// Handshake: a channel word moves in a cycle where ch_re[i]=1, which the
// merger only raises while ch_empty[i]=0; the FIFO pops on that clock edge.
// Downstream takes every cycle with out_we=1; it throttles by raising
// out_afull, and no read or write is launched in a cycle where it is high
// (the registered write lands one cycle after its launch).
interface fit_out_merge_if
  import fit_out_merge_pkg::*;
#(
  parameter int NCH = NCH_DEF,
  parameter int W   = W_DEF
);
  logic [NCH-1:0]   ch_enable;
  logic [NCH-1:0]   ch_empty;
  logic [NCH*W-1:0] ch_data;
  logic [NCH-1:0]   ch_ee;
  logic [NCH-1:0]   ch_re;
  logic             out_afull;
  logic [W-1:0]     out_data;
  logic             out_we;
  logic             out_ee;
  logic             busy;
  state_t           dbg_state;

  modport master (
    input  ch_enable, ch_empty, ch_data, ch_ee, out_afull,
    output ch_re, out_data, out_we, out_ee, busy, dbg_state
  );

  modport slave (
    output ch_enable, ch_empty, ch_data, ch_ee, out_afull,
    input  ch_re, out_data, out_we, out_ee, busy, dbg_state
  );
endinterface

// File: rtl/fit_out_merge_rr_pick.sv
// rr_pick
// Combinational round-robin search: returns the first set bit of req at or
// after index ptr, wrapping modulo N.
//   req[N]    request vector
//   ptr[PW]   starting index
//   grant[PW] index of the chosen request
//   valid     some request was set
module rr_pick #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [PW-1:0] grant,
  output logic          valid
);

  // Walk from the farthest offset down to offset 0 so the nearest request
  // to ptr is the last one written and wins.
  always_comb begin
    grant = '0;
    valid = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % N]) begin
        valid = 1'b1;
        grant = PW'((int'(ptr) + k) % N);
      end
    end
  end

endmodule

// File: rtl/fit_out_merge.sv
// fit_out_merge
// Merges NCH fitter output FIFOs into one stream, event by event. Each
// enabled channel is drained in round-robin bursts of up to MAX_BURST words
// until its end-event marker is read; markers are swallowed, and once every
// enabled channel has delivered its marker a single merged end-event word
// carrying an 8-bit event counter is written.
//   clock, reset  single clock, synchronous active-high reset
//   bus           fit_out_merge_if master modport (see interface header)
module fit_out_merge
  import fit_out_merge_pkg::*;
#(
  parameter int NCH       = NCH_DEF,
  parameter int W         = W_DEF,
  parameter int MAX_BURST = MAX_BURST_DEF
) (
  input  logic            clock,
  input  logic            reset,
  fit_out_merge_if.master bus
);

  localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int BW = $clog2(MAX_BURST + 1);

  state_t         r_state, w_next;
  logic [NCH-1:0] r_active, r_seen;
  logic [PW-1:0]  r_ptr, r_g;
  logic [BW-1:0]  r_burst;
  logic [7:0]     r_evt;
  logic [W-1:0]   r_out_data;
  logic           r_out_we, r_out_ee;

  logic [NCH-1:0] w_req, w_re;
  logic [PW-1:0]  w_pick, w_ptr_nxt;
  logic           w_pick_vld, w_all_seen;
  logic           w_head_empty, w_head_ee, w_rd, w_last;
  logic [W-1:0]   w_head_data;

  // Only channels that are enabled, still owe their marker, and hold data
  // may be granted; an empty channel is revisited on a later pass.
  assign w_req      = r_active & ~r_seen & ~bus.ch_empty;
  assign w_all_seen = ((r_active & ~r_seen) == '0);

  rr_pick #(.N(NCH), .PW(PW)) u_rr_pick (
    .req   (w_req),
    .ptr   (r_ptr),
    .grant (w_pick),
    .valid (w_pick_vld)
  );

  always_comb begin
    w_head_data = '0;
    for (int i = 0; i < NCH; i++) begin
      if (r_g == PW'(i)) w_head_data = bus.ch_data[i*W +: W];
    end
  end

  assign w_head_empty = bus.ch_empty[r_g];
  assign w_head_ee    = bus.ch_ee[r_g];
  assign w_ptr_nxt    = (r_g == PW'(NCH - 1)) ? '0 : r_g + 1'b1;

  // Reset gates the strobe so no FIFO word is popped while being abandoned.
  assign w_rd   = (r_state == S_XFER) && !w_head_empty && !bus.out_afull && !reset;
  // The read that consumes the marker or fills the burst also ends the
  // grant, so a channel switch costs only the one SELECT cycle.
  assign w_last = w_head_ee || (r_burst == BW'(MAX_BURST - 1));

  always_comb begin
    w_re = '0;
    if (w_rd) w_re[r_g] = 1'b1;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (bus.ch_enable != '0) w_next = S_SELECT;
      S_SELECT: begin
        if (w_all_seen)      w_next = S_SEND_EE;
        else if (w_pick_vld) w_next = S_XFER;
      end
      S_XFER: begin
        if (w_head_empty)        w_next = S_SELECT;
        else if (w_rd && w_last) w_next = S_SELECT;
      end
      S_SEND_EE: if (!bus.out_afull) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_active   <= '0;
      r_seen     <= '0;
      r_ptr      <= '0;
      r_g        <= '0;
      r_burst    <= '0;
      r_evt      <= '0;
      r_out_data <= '0;
      r_out_we   <= 1'b0;
      r_out_ee   <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_out_we <= 1'b0;
      r_out_ee <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_active <= bus.ch_enable;
          r_seen   <= '0;
        end
        S_SELECT: begin
          if (!w_all_seen && w_pick_vld) begin
            r_g     <= w_pick;
            r_burst <= '0;
          end
        end
        S_XFER: begin
          if (w_head_empty) begin
            r_ptr <= w_ptr_nxt;
          end else if (w_rd) begin
            if (w_head_ee) begin
              r_seen[r_g] <= 1'b1;
              r_ptr       <= w_ptr_nxt;
            end else begin
              r_out_we   <= 1'b1;
              r_out_data <= w_head_data;
              r_burst    <= r_burst + 1'b1;
              if (w_last) r_ptr <= w_ptr_nxt;
            end
          end
        end
        S_SEND_EE: begin
          if (!bus.out_afull) begin
            r_out_we   <= 1'b1;
            r_out_ee   <= 1'b1;
            r_out_data <= W'(r_evt);
            r_evt      <= r_evt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.ch_re     = w_re;
  assign bus.out_data  = r_out_data;
  assign bus.out_we    = r_out_we;
  assign bus.out_ee    = r_out_ee;
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_fit_out_merge.sv
// tb_fit_out_merge
// Directed bench for fit_out_merge: FWFT FIFO models per channel, an output
// monitor feeding got_q, and an expected queue built from the loaded words.
module tb_fit_out_merge;
  import fit_out_merge_pkg::*;

  localparam int NCH = 4;
  localparam int W   = 32;
  localparam int MB  = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fit_out_merge_if #(.NCH(NCH), .W(W)) bus ();

  fit_out_merge #(.NCH(NCH), .W(W), .MAX_BURST(MB)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  // ---------------- bench state ----------------
  logic [W:0]     fifo_q [NCH][$];
  logic [W:0]     exp_q[$];
  logic [W:0]     got_q[$];
  int             read_log[$];
  int             read_cyc[$];
  int             read_cnt [NCH];
  int             n_checks = 0;
  int             n_errors = 0;
  int             n_viol   = 0;
  int             run      = 0;
  int             max_run  = 0;
  int             cyc      = 0;
  int             tog_cnt  = 0;
  logic           afull_mode = 1'b0;
  logic [NCH-1:0] pend = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- FIFO models and output monitor ----------------
  task automatic drive_fifos();
    logic [NCH-1:0]   e, m;
    logic [NCH*W-1:0] d;
    logic [W:0]       h;
    e = '1; m = '0; d = '0;
    for (int i = 0; i < NCH; i++) begin
      if (fifo_q[i].size() > 0) begin
        h = fifo_q[i][0];
        e[i] = 1'b0;
        m[i] = h[W];
        d[i*W +: W] = h[W-1:0];
      end
    end
    bus.ch_empty = e;
    bus.ch_ee    = m;
    bus.ch_data  = d;
  endtask

  initial begin
    bus.ch_empty  = '1;
    bus.ch_data   = '0;
    bus.ch_ee     = '0;
    bus.out_afull = 1'b0;
  end

  always @(negedge clk) begin
    cyc++;
    // A write seen now was launched in the previous cycle, whose afull is
    // still on the bus because it is only updated below.
    if (bus.out_we === 1'b1) begin
      got_q.push_back({bus.out_ee, bus.out_data});
      if (bus.out_afull) n_viol++;
    end
    for (int i = 0; i < NCH; i++)
      if (pend[i] && fifo_q[i].size() > 0) void'(fifo_q[i].pop_front());
    if (afull_mode) begin
      tog_cnt++;
      if (tog_cnt == 3) begin
        tog_cnt = 0;
        bus.out_afull = ~bus.out_afull;
      end
    end else begin
      bus.out_afull = 1'b0;
    end
    drive_fifos();
    #1;
    pend = bus.ch_re;
    if ($countones(pend) > 1) n_viol++;
    if (bus.out_afull && pend != '0) n_viol++;
    if (pend != '0) begin
      run++;
      if (run > max_run) max_run = run;
      for (int i = 0; i < NCH; i++) begin
        if (pend[i]) begin
          read_cnt[i]++;
          read_log.push_back(i);
          read_cyc.push_back(cyc);
        end
      end
    end else begin
      run = 0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_env();
    for (int i = 0; i < NCH; i++) begin
      fifo_q[i].delete();
      read_cnt[i] = 0;
    end
    exp_q.delete();
    got_q.delete();
    read_log.delete();
    read_cyc.delete();
    n_viol  = 0;
    max_run = 0;
    run     = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.ch_enable = '0;
    afull_mode = 1'b0;
    repeat (2) @(negedge clk);
    clear_env();
    rst = 1'b0;
  endtask

  task automatic push_word(input int ch, input logic [W-1:0] data);
    fifo_q[ch].push_back({1'b0, data});
    exp_q.push_back({1'b0, data});
  endtask

  task automatic push_marker(input int ch);
    fifo_q[ch].push_back({1'b1, W'(32'hEEEE_0000 + ch)});
  endtask

  task automatic push_ee(input int payload);
    exp_q.push_back({1'b1, W'(payload & 255)});
  endtask

  task automatic start(input logic [NCH-1:0] en);
    repeat (2) @(negedge clk);
    bus.ch_enable = en;
  endtask

  // Scoreboard: wait (bounded) for all expected words, then compare in order.
  task automatic run_and_compare(input string tag, input int budget);
    int n, t;
    logic [W:0] e, g;
    n = exp_q.size();
    t = 0;
    while (got_q.size() < n && t < budget) begin
      @(negedge clk);
      t++;
    end
    repeat (4) @(negedge clk);
    check({tag, "_count"}, 64'(got_q.size()), 64'(n));
    for (int i = 0; i < n; i++) begin
      e = exp_q.pop_front();
      if (got_q.size() == 0) break;
      g = got_q.pop_front();
      check($sformatf("%s_word%0d", tag, i), 64'(g), 64'(e));
    end
  endtask

  // ---------------- tests ----------------
  initial begin
    bus.ch_enable = '0;

    // Test 1: four channels, 3 words + marker each
    do_reset();
    check("rst_busy",  64'(bus.busy), 64'(0));
    check("rst_we",    64'(bus.out_we), 64'(0));
    check("rst_ee",    64'(bus.out_ee), 64'(0));
    check("rst_data",  64'(bus.out_data), 64'(0));
    check("rst_re",    64'(bus.ch_re), 64'(0));
    check("rst_state", 64'(bus.dbg_state), 64'(S_IDLE));
    for (int i = 0; i < NCH; i++) begin
      for (int j = 0; j < 3; j++) push_word(i, W'(i * 256 + j));
      push_marker(i);
    end
    push_ee(0);
    start(4'b1111);
    run_and_compare("t1", 200);
    check("t1_viol", 64'(n_viol), 64'(0));

    // Test 2: long channel 0, markers only elsewhere
    do_reset();
    for (int j = 0; j < 40; j++) push_word(0, W'(32'h1000 + j));
    for (int i = 0; i < NCH; i++) push_marker(i);
    push_ee(0);
    start(4'b1111);
    run_and_compare("t2", 300);
    check("t2_nreads", 64'(read_log.size()), 64'(44));
    if (read_log.size() == 44) begin
      check("t2_rd16_ch", 64'(read_log[16]), 64'(1));
      check("t2_rd17_ch", 64'(read_log[17]), 64'(2));
      check("t2_rd18_ch", 64'(read_log[18]), 64'(3));
      check("t2_rd19_ch", 64'(read_log[19]), 64'(0));
      check("t2_gap_b1",  64'(read_cyc[1] - read_cyc[0]), 64'(1));
      check("t2_gap_sw",  64'(read_cyc[16] - read_cyc[15]), 64'(2));
      check("t2_gap_b2",  64'(read_cyc[35] - read_cyc[34]), 64'(2));
    end
    check("t2_max_run", 64'(max_run), 64'(16));
    check("t2_viol",    64'(n_viol), 64'(0));

    // Test 3: out_afull toggled every 3 cycles
    do_reset();
    for (int j = 0; j < 10; j++) push_word(0, W'(32'h3000 + j));
    push_marker(0);
    for (int j = 0; j < 5; j++) push_word(1, W'(32'h3100 + j));
    push_marker(1);
    push_ee(0);
    afull_mode = 1'b1;
    start(4'b0011);
    run_and_compare("t3", 400);
    check("t3_viol",  64'(n_viol), 64'(0));
    check("t3_rd_c0", 64'(read_cnt[0]), 64'(11));
    check("t3_rd_c1", 64'(read_cnt[1]), 64'(6));
    afull_mode = 1'b0;

    // Test 4: partial enable mask 0101
    do_reset();
    push_word(0, W'(32'h4000)); push_word(0, W'(32'h4001)); push_marker(0);
    fifo_q[1].push_back({1'b0, W'(32'h4100)}); push_marker(1);
    push_word(2, W'(32'h4200)); push_marker(2);
    fifo_q[3].push_back({1'b0, W'(32'h4300)}); push_marker(3);
    push_ee(0);
    start(4'b0101);
    run_and_compare("t4", 200);
    check("t4_rd_c1", 64'(read_cnt[1]), 64'(0));
    check("t4_rd_c3", 64'(read_cnt[3]), 64'(0));

    // Test 5: 257 marker-only events, event counter wraps
    do_reset();
    for (int k = 0; k < 257; k++) begin
      push_marker(0);
      push_ee(k);
    end
    start(4'b0001);
    run_and_compare("t5", 3000);

    // Test 6: reset in the middle of a transfer
    do_reset();
    for (int j = 0; j < 20; j++) push_word(0, W'(32'h6000 + j));
    push_marker(0);
    start(4'b0001);
    begin
      int t;
      t = 0;
      while (got_q.size() < 5 && t < 100) begin
        @(negedge clk);
        t++;
      end
      check("t6_started", 64'(got_q.size() >= 5), 64'(1));
    end
    rst = 1'b1;
    @(negedge clk);
    check("t6_we",   64'(bus.out_we), 64'(0));
    check("t6_ee",   64'(bus.out_ee), 64'(0));
    check("t6_data", 64'(bus.out_data), 64'(0));
    check("t6_re",   64'(bus.ch_re), 64'(0));
    check("t6_busy", 64'(bus.busy), 64'(0));
    @(negedge clk);
    clear_env();
    push_marker(1);
    push_ee(0);
    bus.ch_enable = 4'b0010;
    rst = 1'b0;
    run_and_compare("t6", 100);
    check("t6_rd_c0", 64'(read_cnt[0]), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d", n_checks);
    $fatal(1, "watchdog");
  end

endmodule
